// File: rtl/wf_dpbram_player_pkg.sv
// wf_pkg: shared sizes, FSM state type and length clamp for the waveform player.
package wf_pkg;
    localparam int WF_DEPTH = 1024;
    localparam int WF_AW    = 10;
    localparam int WF_DW    = 16;
    localparam int WF_LW    = WF_AW + 1;

    typedef enum logic {IDLE, RUN} wf_state_e;

    function automatic logic [WF_LW-1:0] wf_clamp_len(input logic [31:0] max_cnt);
        return (max_cnt > 32'(WF_DEPTH)) ? WF_LW'(WF_DEPTH) : max_cnt[WF_LW-1:0];
    endfunction
endpackage

// File: rtl/wf_dpbram_player_if.sv
// wf_dpbram_player_if: register-slave side bundle of the waveform player.
interface wf_dpbram_player_if;
    import wf_pkg::*;
    logic             i_wf_mode_start;
    logic             i_wf_write_en;
    logic [WF_AW-1:0] i_wf_write_addr;
    logic [WF_DW-1:0] i_wf_write_data;
    logic [31:0]      i_wf_max_cnt;
    logic [WF_DW-1:0] o_wf_data;
    logic             o_wf_data_valid;
    logic             o_wf_busy;
    logic [31:0]      o_wf_read_cnt;

    modport master (
        output i_wf_mode_start, i_wf_write_en, i_wf_write_addr, i_wf_write_data, i_wf_max_cnt,
        input  o_wf_data, o_wf_data_valid, o_wf_busy, o_wf_read_cnt
    );
    modport slave (
        input  i_wf_mode_start, i_wf_write_en, i_wf_write_addr, i_wf_write_data, i_wf_max_cnt,
        output o_wf_data, o_wf_data_valid, o_wf_busy, o_wf_read_cnt
    );
endinterface

// File: rtl/wf_dpbram_player_dpbram.sv
// wf_dpbram: simple dual-port read-first block RAM with registered read data.
module wf_dpbram
    import wf_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [WF_AW-1:0] i_waddr,
    input  logic [WF_DW-1:0] i_wdata,
    input  logic             i_re,
    input  logic [WF_AW-1:0] i_raddr,
    output logic [WF_DW-1:0] o_rdata
);
    logic [WF_DW-1:0] r_mem [WF_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/wf_dpbram_player.sv
// wf_dpbram_player: captures PS-written samples and replays 0..len-1 cyclically,
// one sample every SAMPLE_DIV clocks, while waveform mode is on.
module wf_dpbram_player
    import wf_pkg::*;
#(
    parameter int SAMPLE_DIV = 100
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    wf_dpbram_player_if.slave bus
);
    localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    wf_state_e        r_state, w_state_nxt;
    logic             r_start, r_pend, r_valid;
    logic             w_rise, w_re, w_emit;
    logic [WF_LW-1:0] r_len, w_len;
    logic [WF_AW-1:0] r_rd_addr;
    logic [DIV_W-1:0] r_div;
    logic [WF_DW-1:0] w_ram_q, r_data;
    logic [31:0]      r_cnt;

    wf_dpbram u_ram (
        .i_clk   (i_clk),
        .i_we    (bus.i_wf_write_en),
        .i_waddr (bus.i_wf_write_addr),
        .i_wdata (bus.i_wf_write_data),
        .i_re    (w_re),
        .i_raddr (r_rd_addr),
        .o_rdata (w_ram_q)
    );

    // The start edge itself issues the read of address 0 so the first sample lands two clocks later.
    always_comb begin
        w_len       = wf_clamp_len(bus.i_wf_max_cnt);
        w_rise      = bus.i_wf_mode_start & ~r_start;
        w_state_nxt = r_state;
        w_re        = 1'b0;
        if (r_state == IDLE) begin
            if (w_rise && w_len != '0) begin
                w_state_nxt = RUN;
                w_re        = 1'b1;
            end
        end else if (!bus.i_wf_mode_start) begin
            w_state_nxt = IDLE;
        end else begin
            w_re = (r_div == '0);
        end
    end

    // A read still in the pipe when playback stops is dropped here.
    assign w_emit = r_pend & (r_state == RUN) & bus.i_wf_mode_start;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_start   <= 1'b0;
            r_pend    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_div     <= '0;
            r_rd_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= bus.i_wf_mode_start;
            r_pend  <= w_re;
            r_valid <= w_emit;
            if (w_emit) begin
                r_data <= w_ram_q;
                r_cnt  <= r_cnt + 32'd1;
            end
            if (r_state == IDLE && w_state_nxt == RUN) begin
                r_len     <= w_len;
                r_cnt     <= '0;
                r_div     <= DIV_W'(1);
                r_rd_addr <= (w_len == WF_LW'(1)) ? '0 : WF_AW'(1);
            end else if (w_state_nxt == IDLE) begin
                r_div     <= '0;
                r_rd_addr <= '0;
            end else begin
                r_div <= (r_div == DIV_W'(SAMPLE_DIV - 1)) ? '0 : r_div + DIV_W'(1);
                if (w_re) r_rd_addr <= ({1'b0, r_rd_addr} == r_len - WF_LW'(1)) ? '0 : r_rd_addr + WF_AW'(1);
            end
        end
    end

    assign bus.o_wf_data       = r_data;
    assign bus.o_wf_data_valid = r_valid;
    assign bus.o_wf_busy       = (r_state == RUN);
    assign bus.o_wf_read_cnt   = r_cnt;
endmodule

// File: tb/tb_wf_dpbram_player.sv
// tb_wf_dpbram_player: scoreboard bench; a sample-level player model predicts every strobe.
module tb_wf_dpbram_player;
    localparam int DIV = 4;

    typedef struct {
        logic [15:0] d;
        int unsigned c;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wf_dpbram_player_if bus();

    wf_dpbram_player #(.SAMPLE_DIV(DIV)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    logic [15:0] mem_m [1024];
    int          cyc = 0, t0 = 0, len_m = 0, start_cyc = -1, rst_cyc = -1;
    logic        run_m = 1'b0, prev_m = 1'b0;
    int          checks = 0, errors = 0;
    logic [15:0] exp_d = '0;
    int unsigned exp_c = 0;

    // Reference: sample k of a run is read k*DIV clocks after the start edge, from address k mod len.
    always @(posedge clk) begin
        int k, ml;
        cyc++;
        ml = (bus.i_wf_max_cnt > 1024) ? 1024 : int'(bus.i_wf_max_cnt);
        if (!rst_n) begin
            run_m = 1'b0;
            q.delete();
            rst_cyc = cyc;
        end else if (run_m && !bus.i_wf_mode_start) begin
            run_m = 1'b0;
            while (q.size() != 0 && q[$].due >= cyc) void'(q.pop_back());
        end else if (run_m) begin
            if ((cyc - t0) % DIV == 0) begin
                k = (cyc - t0) / DIV;
                q.push_back('{mem_m[k % len_m], k + 1, cyc + 1});
            end
        end else if (bus.i_wf_mode_start && !prev_m && ml > 0) begin
            run_m = 1'b1;
            t0 = cyc;
            len_m = ml;
            start_cyc = cyc;
            q.push_back('{mem_m[0], 1, cyc + 1});
        end
        prev_m = rst_n ? bus.i_wf_mode_start : 1'b0;
        if (bus.i_wf_write_en) mem_m[bus.i_wf_write_addr] = bus.i_wf_write_data;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", n, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic ev;
        if (cyc > 0) begin
            if (rst_cyc == cyc) begin
                exp_d = '0;
                exp_c = 0;
            end
            if (start_cyc == cyc) exp_c = 0;
            ev = (q.size() != 0 && q[0].due == cyc);
            if (ev) begin
                exp_d = q[0].d;
                exp_c = q[0].c;
                void'(q.pop_front());
            end
            chk("valid", 32'(bus.o_wf_data_valid), 32'(ev));
            chk("data", 32'(bus.o_wf_data), 32'(exp_d));
            chk("read_cnt", bus.o_wf_read_cnt, exp_c);
            chk("busy", 32'(bus.o_wf_busy), 32'(run_m));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        bus.i_wf_write_en   = 1'b1;
        bus.i_wf_write_addr = 10'(a);
        bus.i_wf_write_data = d;
        tick(1);
        bus.i_wf_write_en = 1'b0;
    endtask

    initial begin
        bus.i_wf_mode_start = 1'b0;
        bus.i_wf_write_en   = 1'b0;
        bus.i_wf_write_addr = '0;
        bus.i_wf_write_data = '0;
        bus.i_wf_max_cnt    = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        // basic playback of four samples
        for (int i = 0; i < 4; i++) wr(i, 16'(17 * (i + 1)));
        bus.i_wf_max_cnt = 4;
        bus.i_wf_mode_start = 1'b1;
        tick(8 * DIV + 4);
        bus.i_wf_mode_start = 1'b0;
        tick(5);
        // stop after five samples, then restart
        bus.i_wf_mode_start = 1'b1;
        tick(5 * DIV);
        bus.i_wf_mode_start = 1'b0;
        tick(8);
        bus.i_wf_mode_start = 1'b1;
        tick(12);
        bus.i_wf_mode_start = 1'b0;
        tick(4);
        // overwrite address 2 in the very cycle it is being read
        bus.i_wf_mode_start = 1'b1;
        tick(2 * DIV);
        wr(2, 16'hBEEF);
        tick(6 * DIV);
        bus.i_wf_mode_start = 1'b0;
        tick(4);
        // zero length never starts
        bus.i_wf_max_cnt = 0;
        bus.i_wf_mode_start = 1'b1;
        tick(10);
        bus.i_wf_mode_start = 1'b0;
        tick(3);
        // clamp to full depth and wrap past the last address
        for (int i = 0; i < 1024; i++) wr(i, 16'($urandom));
        bus.i_wf_max_cnt = 2000;
        bus.i_wf_mode_start = 1'b1;
        tick(1025 * DIV + 4);
        bus.i_wf_mode_start = 1'b0;
        tick(3);
        // reset during playback
        bus.i_wf_max_cnt = 4;
        bus.i_wf_mode_start = 1'b1;
        tick(10);
        rst_n = 1'b0;
        bus.i_wf_mode_start = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(10);
        bus.i_wf_mode_start = 1'b1;
        tick(12);
        bus.i_wf_mode_start = 1'b0;
        tick(3);
        // random lengths, run times, live writes and max_cnt changes
        for (int r = 0; r < 12; r++) begin
            bus.i_wf_max_cnt = $urandom_range(0, 8);
            bus.i_wf_mode_start = 1'b1;
            repeat ($urandom_range(3, 50)) begin
                bus.i_wf_write_en   = ($urandom_range(0, 3) == 0);
                bus.i_wf_write_addr = 10'($urandom_range(0, 7));
                bus.i_wf_write_data = 16'($urandom);
                if ($urandom_range(0, 9) == 0) bus.i_wf_max_cnt = $urandom_range(0, 8);
                tick(1);
            end
            bus.i_wf_write_en = 1'b0;
            bus.i_wf_mode_start = 1'b0;
            tick($urandom_range(1, 6));
        end
        tick(6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wf_dpbram_player.md
# wf_dpbram_player

Waveform sample store and playback engine that sits directly downstream of the waveform AXI4-Lite register slave. It captures PS-written 16-bit waveform samples into a 1024-deep dual-port block RAM and, once waveform mode is started, replays samples 0..max_cnt-1 cyclically at a fixed sample rate. Played samples feed the power-supply setpoint path, and the played-sample count is returned to the register slave for PS readback.

## Interface
- SAMPLE_DIV, 100: clocks per output sample, ≥2.
- WF_DEPTH, 1024: RAM depth; address width is clog2(WF_DEPTH)=10.
- WF_DW, 16: sample width.

- i_clk  in  1  system clock, same domain as the register slave.
- i_rst_n  in  1  reset; synchronous and active-low.
- i_wf_mode_start  in  1  level; 1 = play, 0 = stop.
- i_wf_write_en  in  1  level; 1 = write i_wf_write_data at i_wf_write_addr every cycle.
- i_wf_write_addr  in  10  RAM write address.
- i_wf_write_data  in  16  RAM write data.
- i_wf_max_cnt  in  32  number of samples in one waveform period.
- o_wf_data  out  16  current sample, held between updates.
- o_wf_data_valid  out  1  one-cycle strobe when o_wf_data updates.
- o_wf_busy  out  1  high in RUN.
- o_wf_read_cnt  out  32  samples emitted since the last start; to the register slave.

## Operation
- The write port is independent of the FSM. Writes are accepted in every state, including RUN.
- The RAM is read-first. A same-cycle read and write to one address returns the old data.
- States:
  - IDLE: reset state.
    - On a rising edge of i_wf_mode_start, latch len = min(i_wf_max_cnt, 1024), then go to RUN.
    - If the latched len is 0, stay in IDLE and re-arm on the next rising edge.
  - RUN:
    - rd_addr starts at 0. div_cnt counts 0..SAMPLE_DIV-1 and wraps.
    - When div_cnt==0, issue a read at rd_addr. rd_addr advances by 1 and wraps to 0 after len-1.
    - i_wf_mode_start low returns the FSM to IDLE on the next clock.
    - Any in-flight read is discarded: no valid strobe is produced for it.
- Start detection uses a registered copy of i_wf_mode_start. Holding the input high does not restart playback.
- Changes to i_wf_max_cnt during RUN are ignored until the next start.
- o_wf_read_cnt:
  - Cleared on entry to RUN.
  - Increments by 1 with each o_wf_data_valid.
  - Wraps modulo 2^32.
  - Holds its value in IDLE.
- o_wf_data holds its last value in IDLE. It is cleared only by reset.

## Timing
- Reset values: o_wf_data=0, o_wf_data_valid=0, o_wf_busy=0, o_wf_read_cnt=0, FSM=IDLE, rd_addr=0, div_cnt=0, start register=0. RAM contents are not reset.
- Start edge at cycle T (start high at T, low at T-1):
  - RUN entered at T+1; o_wf_busy=1 from T+1.
  - First read issued at T+1.
  - o_wf_data and o_wf_data_valid update at T+2.
- Subsequent samples follow every SAMPLE_DIV cycles: T+2+k·SAMPLE_DIV.
- Read latency from address to o_wf_data is 2 cycles: RAM output register plus output register.
- A RAM write at cycle W is readable by a read issued at W+1 or later.
- Stop: start low at cycle S gives o_wf_busy=0 at S+1. No valid strobe occurs at or after S+1.
- Reset mid-RUN: all registers take reset values on the next clock edge.

## Structure
- Shared package wf_pkg holds:
  - WF_DEPTH, WF_AW=10, WF_DW=16;
  - the state enum {IDLE, RUN};
  - the clamp function for len.
- One sub-module: wf_dpbram.
  - Simple dual port: one write port, one read port.
  - 1024x16, read-first, registered read output, inferred block RAM.
- The top module contains the start-edge detector, the FSM, the divider, the address counter, the output register and the read counter.

## Test plan
- Basic playback:
  - Stimulus: write samples 0x0011, 0x0022, 0x0033, 0x0044 at addresses 0..3; max_cnt=4; SAMPLE_DIV=4; start.
  - Response: valid every 4 cycles with data 11,22,33,44,11,22…; read_cnt=8 after eight strobes; first valid 2 cycles after the start edge.
- Clamp:
  - Stimulus: max_cnt=2000.
  - Response: rd_addr wraps 1023→0; the 1025th sample equals the contents of address 0.
- Zero length:
  - Stimulus: max_cnt=0, then start.
  - Response: o_wf_busy stays 0, no valid strobes, read_cnt unchanged.
- Stop and restart:
  - Stimulus: deassert start after 5 samples; wait; assert again.
  - Response: busy drops 1 cycle after the deassert; o_wf_data holds the 5th sample; after restart, read_cnt restarts from 1 and the sequence restarts at address 0.
- Write during RUN:
  - Stimulus: overwrite address 2 with 0xBEEF while playing a 4-sample waveform.
  - Response: the next pass outputs 0xBEEF at position 2; a same-cycle read/write collision returns the old value.
- Reset mid-RUN:
  - Stimulus: pull i_rst_n low for 1 cycle during RUN.
  - Response: all outputs are 0 on the next edge; FSM is IDLE; no playback until a new rising edge of start.
